// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle of the arbiter: request lanes in, muxed stream out.
interface mux4_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] in_data;
  logic [N_REQ-1:0]        gnt;
  logic [SEL_W-1:0]        sel;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ready;
  logic [N_REQ-1:0]        beat_ack;

  modport master (
    output req, in_data, out_ready,
    input  gnt, sel, out_valid, out_data, beat_ack
  );

  modport slave (
    input  req, in_data, out_ready,
    output gnt, sel, out_valid, out_data, beat_ack
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request scanning last+1, last+2, ... mod 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    any   = |req;
    idx   = last;
    found = 1'b0;
    cand  = '0;
    // k = N_REQ wraps back to last itself, so the previous winner is scanned last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 data mux; grants are held per burst and capped
// at MAX_HOLD accepted beats so every requester gets its turn.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux4_rr_arbiter_if.slave       bus
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             accept;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_data  = bus.in_data[int'(sel_q)*DATA_W +: DATA_W];
  assign bus.out_valid = (state_q == BUSY) && bus.req[sel_q];
  assign accept        = bus.out_valid && bus.out_ready;
  assign bus.beat_ack  = accept ? onehot(sel_q) : '0;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = BUSY;
          gnt_d      = onehot(pick_idx);
          sel_d      = pick_idx;
          last_d     = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        // sel is left untouched on release; it is only meaningful while gnt != 0.
        if (!bus.req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (accept) begin
          if (beat_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            state_d = IDLE;
            gnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; the comb block above uses blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      last_q     <= SEL_W'(N_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with MAX_HOLD=2 for rotation,
// one with MAX_HOLD=8 for early release, backpressure, sole-requester cap and reset.
module tb_mux4_rr_arbiter;

  logic clk;
  logic rst_n;

  int n_vec = 0;
  int n_bad = 0;

  mux4_rr_arbiter_if #(.DATA_W(8)) bus8 ();
  mux4_rr_arbiter_if #(.DATA_W(8)) bus2 ();

  mux4_rr_arbiter #(.DATA_W(8), .MAX_HOLD(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  mux4_rr_arbiter #(.DATA_W(8), .MAX_HOLD(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         grant_seq [5] = '{0, 1, 2, 3, 0};
  logic [7:0] lane2     [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [3:0] exp_oh;

  initial begin
    rst_n          = 1'b0;
    bus8.req       = 4'hF;
    bus8.in_data   = 32'h33221100;
    bus8.out_ready = 1'b1;
    bus2.req       = 4'h0;
    bus2.in_data   = 32'hD3C2B1A0;
    bus2.out_ready = 1'b1;

    // 1: reset holds everything at zero even with all requests high
    @(negedge clk);
    check("rst_gnt", bus8.gnt, 0);
    check("rst_sel", bus8.sel, 0);
    check("rst_valid", bus8.out_valid, 0);
    check("rst_ack", bus8.beat_ack, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_gnt", bus8.gnt, 4'b0001);
    check("rst_first_sel", bus8.sel, 0);
    bus8.req = 4'h0;
    @(negedge clk);
    check("rst_drop_gnt", bus8.gnt, 0);

    // 2: rotation with cap 2, one idle cycle between grants
    bus2.req = 4'hF;
    for (int gi = 0; gi < 5; gi++) begin
      exp_oh = 4'b0001 << grant_seq[gi];
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        check("rot_gnt", bus2.gnt, exp_oh);
        check("rot_sel", bus2.sel, grant_seq[gi]);
        check("rot_ack", bus2.beat_ack, exp_oh);
        check("rot_data", bus2.out_data, lane2[grant_seq[gi]]);
      end
      @(negedge clk);
      check("rot_idle_gnt", bus2.gnt, 0);
      check("rot_idle_valid", bus2.out_valid, 0);
    end
    bus2.req = 4'h0;

    // 3: requester 2 sends three beats then drops its request
    bus8.in_data[23:16] = 8'h20;
    bus8.req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("early_gnt", bus8.gnt, 4'b0100);
      check("early_sel", bus8.sel, 2);
      check("early_valid", bus8.out_valid, 1);
      check("early_data", bus8.out_data, 8'h20 + k);
      check("early_ack", bus8.beat_ack, 4'b0100);
      bus8.in_data[23:16] = 8'h21 + 8'(k);
    end
    @(negedge clk);
    bus8.req = 4'h0;
    #1;
    check("early_noval", bus8.out_valid, 0);
    check("early_noack", bus8.beat_ack, 0);
    check("early_hold", bus8.gnt, 4'b0100);
    @(negedge clk);
    check("early_rel", bus8.gnt, 0);

    // 4: backpressure freezes the burst; cap of 8 still counted after resume
    bus8.in_data[15:8] = 8'h55;
    bus8.out_ready = 1'b0;
    bus8.req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", bus8.out_valid, 1);
      check("bp_data", bus8.out_data, 8'h55);
      check("bp_gnt", bus8.gnt, 4'b0010);
      check("bp_noack", bus8.beat_ack, 0);
    end
    bus8.out_ready = 1'b1;
    #1;
    check("bp_ack", bus8.beat_ack, 4'b0010);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check("bp_ack", bus8.beat_ack, 4'b0010);
      check("bp_gnt", bus8.gnt, 4'b0010);
    end
    @(negedge clk);
    check("bp_cap_rel", bus8.gnt, 0);
    bus8.req = 4'h0;

    // 5: sole requester hits the cap and is re-granted after one idle cycle
    bus8.req = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("sole_gnt", bus8.gnt, 4'b1000);
      check("sole_sel", bus8.sel, 3);
      check("sole_ack", bus8.beat_ack, 4'b1000);
    end
    @(negedge clk);
    check("sole_idle_gnt", bus8.gnt, 0);
    check("sole_idle_valid", bus8.out_valid, 0);
    @(negedge clk);
    check("sole_regrant", bus8.gnt, 4'b1000);
    check("sole_resel", bus8.sel, 3);
    bus8.req = 4'h0;
    @(negedge clk);
    @(negedge clk);

    // 6: reset in the middle of a burst on requester 1
    bus8.req = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_gnt", bus8.gnt, 4'b0010);
      check("mid_ack", bus8.beat_ack, 4'b0010);
    end
    rst_n = 1'b0;
    bus8.req = 4'b1001;
    #1;
    check("mid_rst_gnt", bus8.gnt, 0);
    check("mid_rst_valid", bus8.out_valid, 0);
    check("mid_rst_ack", bus8.beat_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_after_gnt", bus8.gnt, 4'b0001);
    check("mid_after_sel", bus8.sel, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
